// File: rtl/vslc_scan_sequencer.sv
// Scan-cycle controller for the vslc logic core: latch inputs, fetch/execute
// every instruction of the program, commit outputs, repeat while run is high.
module vslc_scan_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int WDT_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  prog_len,
  input  logic               ovr_clr,
  output logic               fetch_req,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic               fetch_ack,
  input  logic [INSTR_W-1:0] fetch_data,
  output logic               exec_valid,
  output logic [INSTR_W-1:0] exec_instr,
  input  logic               exec_done,
  output logic               in_latch,
  output logic               out_commit,
  output logic               addr_strobe,
  output logic               scan_cycle_clk,
  output logic               scan_overrun,
  output logic               busy
);

  // Handshakes: fetch_req stays high in FETCH until a one-cycle fetch_ack is
  // sampled; exec_valid stays high in EXEC until a one-cycle exec_done is
  // sampled. Pulses seen in any other state are ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  localparam logic [WDT_W-1:0] WDT_MAX = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;
  logic               ovr_q, ovr_d;
  logic               sclk_q, sclk_d;
  logic               strobe_q, strobe_d;
  logic               in_scan;
  logic               wdt_exp;
  logic               last_instr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      instr_q  <= '0;
      wdt_q    <= '0;
      ovr_q    <= 1'b0;
      sclk_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      instr_q  <= instr_d;
      wdt_q    <= wdt_d;
      ovr_q    <= ovr_d;
      sclk_q   <= sclk_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    in_scan    = (state_q == S_FETCH) || (state_q == S_EXEC);
    wdt_exp    = in_scan && (wdt_q == WDT_MAX);
    last_instr = (pc_q == (len_q - ADDR_W'(1)));

    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    wdt_d   = wdt_q;
    sclk_d  = sclk_q;

    // Watchdog expiry outranks a coincident ack/done.
    case (state_q)
      S_IDLE: begin
        if (run && (prog_len != '0) && !ovr_q) state_d = S_LATCH;
      end
      S_LATCH: begin
        len_d   = prog_len;
        pc_d    = '0;
        wdt_d   = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wdt_exp) begin
          state_d = S_IDLE;
        end else if (fetch_ack) begin
          instr_d = fetch_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (wdt_exp) begin
          state_d = S_IDLE;
        end else if (exec_done) begin
          if (last_instr) begin
            state_d = S_COMMIT;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_COMMIT: begin
        sclk_d  = ~sclk_q;
        state_d = run ? S_LATCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (in_scan && (wdt_q != WDT_MAX)) wdt_d = wdt_q + WDT_W'(1);

    // A coincident expiry keeps the flag set even if ovr_clr is pulsed.
    if (wdt_exp)      ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;

    strobe_d = (state_d == S_FETCH) && (state_q != S_FETCH);
  end

  always_comb begin
    fetch_req      = (state_q == S_FETCH);
    exec_valid     = (state_q == S_EXEC);
    in_latch       = (state_q == S_LATCH);
    out_commit     = (state_q == S_COMMIT);
    busy           = (state_q != S_IDLE);
    addr_strobe    = strobe_q;
    fetch_addr     = pc_q;
    exec_instr     = instr_q;
    scan_cycle_clk = sclk_q;
    scan_overrun   = ovr_q;
  end

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Bench for vslc_scan_sequencer: procedural scan model compared every cycle,
// plus directed scenarios with hand-computed literal checks.
module tb_vslc_scan_sequencer;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int WDT_W   = 4;
  localparam int WDT_LIM = (1 << WDT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               run = 1'b0;
  logic [ADDR_W-1:0]  prog_len = '0;
  logic               ovr_clr = 1'b0;
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_ack = 1'b0;
  logic [INSTR_W-1:0] fetch_data = '0;
  logic               exec_valid;
  logic [INSTR_W-1:0] exec_instr;
  logic               exec_done = 1'b0;
  logic               in_latch;
  logic               out_commit;
  logic               addr_strobe;
  logic               scan_cycle_clk;
  logic               scan_overrun;
  logic               busy;

  vslc_scan_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .WDT_W(WDT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_len(prog_len), .ovr_clr(ovr_clr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .exec_valid(exec_valid), .exec_instr(exec_instr),
    .exec_done(exec_done), .in_latch(in_latch), .out_commit(out_commit),
    .addr_strobe(addr_strobe), .scan_cycle_clk(scan_cycle_clk),
    .scan_overrun(scan_overrun), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [31:0] got_vec();
    return {fetch_req, exec_valid, in_latch, out_commit, addr_strobe,
            scan_cycle_clk, scan_overrun, busy, fetch_addr, exec_instr};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- responders (drive ack/done/data at negedge) ----------------
  int ack_lat = 0;
  int done_lat = 0;
  bit force_ack = 0;
  bit force_done = 0;
  bit spur_en = 0;
  int req_cnt = 0;
  int val_cnt = 0;

  initial forever begin
    bit a, d;
    @(negedge clk);
    a = 0;
    d = 0;
    if (fetch_req) begin
      a = (ack_lat >= 0) && (req_cnt == ack_lat);
      req_cnt++;
    end else req_cnt = 0;
    if (exec_valid) begin
      d = (done_lat >= 0) && (val_cnt == done_lat);
      val_cnt++;
    end else val_cnt = 0;
    fetch_ack  = a | force_ack | (spur_en & exec_valid);
    exec_done  = d | force_done | (spur_en & fetch_req);
    fetch_data = {fetch_addr ^ 8'h3c, ~fetch_addr};
  end

  // ---------------- behavioural scan model ----------------
  bit m_ok = 0;
  bit m_abort = 0;
  logic [ADDR_W-1:0]  m_pc = '0;
  logic [ADDR_W-1:0]  m_len = '0;
  logic [INSTR_W-1:0] m_instr = '0;
  bit m_sclk = 0, m_ovr = 0, m_ovr_old = 0;
  bit e_req = 0, e_val = 0, e_lat = 0, e_com = 0, e_stb = 0, e_busy = 0;
  int m_cnt = 0;

  function automatic void m_out(bit req, bit val, bit lat, bit com, bit stb);
    e_req = req; e_val = val; e_lat = lat; e_com = com; e_stb = stb;
    e_busy = req | val | lat | com;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_abort = 1; m_ok = 1;
      m_pc = '0; m_len = '0; m_instr = '0; m_sclk = 0; m_ovr = 0;
      m_out(0, 0, 0, 0, 0);
    end else begin
      m_ovr_old = m_ovr;
      if (ovr_clr) m_ovr = 0;
    end
  endtask

  // res: 0 = reset hit, 1 = watchdog abort, 2 = committed
  task automatic m_scan(output int res);
    tick();
    if (m_abort) begin res = 0; return; end
    m_len = prog_len;
    m_pc = '0;
    m_cnt = 0;
    forever begin
      m_out(1, 0, 0, 0, 1);
      forever begin
        tick();
        if (m_abort) begin res = 0; return; end
        if (m_cnt == WDT_LIM) begin m_ovr = 1; m_out(0, 0, 0, 0, 0); res = 1; return; end
        m_cnt++;
        if (fetch_ack) begin m_instr = fetch_data; break; end
        m_out(1, 0, 0, 0, 0);
      end
      m_out(0, 1, 0, 0, 0);
      forever begin
        tick();
        if (m_abort) begin res = 0; return; end
        if (m_cnt == WDT_LIM) begin m_ovr = 1; m_out(0, 0, 0, 0, 0); res = 1; return; end
        m_cnt++;
        if (exec_done) break;
      end
      if (int'(m_pc) == int'(m_len) - 1) break;
      m_pc = m_pc + 8'd1;
    end
    m_out(0, 0, 0, 1, 0);
    tick();
    if (m_abort) begin res = 0; return; end
    m_sclk = !m_sclk;
    res = 2;
  endtask

  task automatic m_top();
    bit chain = 0;
    int res;
    forever begin
      if (!chain) begin
        m_out(0, 0, 0, 0, 0);
        do begin
          tick();
          if (m_abort) return;
        end while (!(run && prog_len != 0 && !m_ovr_old));
      end
      m_out(0, 0, 1, 0, 0);
      m_scan(res);
      if (res == 0) return;
      chain = (res == 2) && run;
    end
  endtask

  initial forever begin
    m_abort = 0;
    m_top();
  end

  // ---------------- compare + monitor ----------------
  int cyc = 0;
  int n_latch = 0, n_commit = 0, n_strobe = 0;
  logic [ADDR_W-1:0] stb_q[$];
  int last_lat = -1, lg_min = 1000, lg_max = 0;
  int last_sck = -1, sg_min = 1000, sg_max = 0;
  bit prev_sclk = 0;

  initial forever begin
    logic [31:0] exp_v;
    @(negedge clk);
    cyc++;
    if (m_ok) begin
      exp_v = {e_req, e_val, e_lat, e_com, e_stb, m_sclk, m_ovr, e_busy, m_pc, m_instr};
      n_cmp++;
      if (got_vec() !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, got_vec(), exp_v);
      end
    end
    if (in_latch === 1'b1) begin
      n_latch++;
      if (last_lat >= 0) begin
        if (cyc - last_lat < lg_min) lg_min = cyc - last_lat;
        if (cyc - last_lat > lg_max) lg_max = cyc - last_lat;
      end
      last_lat = cyc;
    end
    if (out_commit === 1'b1) n_commit++;
    if (addr_strobe === 1'b1) begin
      n_strobe++;
      stb_q.push_back(fetch_addr);
    end
    if (scan_cycle_clk !== prev_sclk) begin
      if (last_sck >= 0) begin
        if (cyc - last_sck < sg_min) sg_min = cyc - last_sck;
        if (cyc - last_sck > sg_max) sg_max = cyc - last_sck;
      end
      last_sck = cyc;
    end
    prev_sclk = scan_cycle_clk;
  end

  task automatic clr_mon();
    n_latch = 0; n_commit = 0; n_strobe = 0;
    stb_q.delete();
    last_lat = -1; lg_min = 1000; lg_max = 0;
    last_sck = -1; sg_min = 1000; sg_max = 0;
  endtask

  task automatic chk_addrs(input string name, input int n);
    chk({name, "_cnt"}, n_strobe, n);
    for (int i = 0; i < n && i < stb_q.size(); i++) chk(name, stb_q[i], i);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // reset release with a 3-instruction program
    run = 1; prog_len = 8'd3; ack_lat = 1; done_lat = 0;
    step(3);
    chk("reset_outputs", got_vec(), 32'h0);
    clr_mon();
    rst_n = 1;
    step(1);
    chk("first_latch", in_latch, 1);
    run = 0;
    for (int i = 0; i < 60 && n_commit < 1; i++) step(1);
    chk("t1_commit", n_commit, 1);
    step(1);
    chk("t1_sclk", scan_cycle_clk, 1);
    chk("t1_busy", busy, 0);
    chk_addrs("t1_addr", 3);

    // minimum-length scans back to back
    clr_mon();
    prog_len = 8'd1; ack_lat = 0; done_lat = 0; run = 1;
    step(24);
    run = 0;
    chk("t2_latch_gap_min", lg_min, 4);
    chk("t2_latch_gap_max", lg_max, 4);
    chk("t2_sclk_half_min", sg_min, 4);
    chk("t2_sclk_half_max", sg_max, 4);
    for (int i = 0; i < 20 && busy; i++) step(1);
    chk("t2_idle", busy, 0);

    // drop run in the middle of a scan
    clr_mon();
    prog_len = 8'd4; ack_lat = 0; done_lat = 1; run = 1;
    for (int i = 0; i < 40 && !(exec_valid && fetch_addr == 8'd1); i++) step(1);
    chk("t3_exec_pc1", exec_valid, 1);
    run = 0;
    for (int i = 0; i < 40 && n_commit < 1; i++) step(1);
    chk("t3_commit", n_commit, 1);
    step(6);
    chk("t3_busy", busy, 0);
    chk("t3_latches", n_latch, 1);
    chk_addrs("t3_addr", 4);

    // watchdog expiry with a reader that never acks
    clr_mon();
    prog_len = 8'd2; ack_lat = -1; run = 1;
    for (int i = 0; i < 60 && !scan_overrun; i++) step(1);
    chk("t4_overrun", scan_overrun, 1);
    chk("t4_busy", busy, 0);
    step(4);
    chk("t4_no_commit", n_commit, 0);
    chk("t4_no_restart", n_latch, 1);
    ack_lat = 0; ovr_clr = 1;
    step(1);
    ovr_clr = 0;
    chk("t4_cleared", scan_overrun, 0);
    chk("t4_not_yet", in_latch, 0);
    step(1);
    chk("t4_restart", in_latch, 1);
    run = 0;
    for (int i = 0; i < 20 && busy; i++) step(1);
    chk("t4_idle", busy, 0);

    // spurious pulses and an empty program
    clr_mon();
    run = 1; prog_len = 8'd0; force_ack = 1; force_done = 1;
    step(1);
    force_ack = 0; force_done = 0;
    step(3);
    chk("t5_len0_busy", busy, 0);
    chk("t5_len0_latch", n_latch, 0);
    prog_len = 8'd2; ack_lat = 1; done_lat = 1; spur_en = 1;
    step(1);
    run = 0;
    for (int i = 0; i < 40 && n_commit < 1; i++) step(1);
    chk("t5_commit", n_commit, 1);
    step(2);
    spur_en = 0;
    chk("t5_busy", busy, 0);
    chk_addrs("t5_addr", 2);

    // reset while an instruction is executing
    clr_mon();
    prog_len = 8'd3; ack_lat = 0; done_lat = 3; run = 1;
    for (int i = 0; i < 20 && !exec_valid; i++) step(1);
    chk("t6_in_exec", exec_valid, 1);
    rst_n = 0;
    step(1);
    chk("t6_reset_outputs", got_vec(), 32'h0);
    run = 0; rst_n = 1; force_done = 1;
    step(1);
    force_done = 0;
    step(3);
    chk("t6_busy", busy, 0);
    chk("t6_no_commit", n_commit, 0);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
